// File: rtl/accumulator_window_avg.sv
// rtl/accumulator_window_avg.sv - windowed average of a running total with a valid/ready holding register
module accumulator_window_avg #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2_N     = 3
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic [DATA_WIDTH-1:0] i_TOTAL_IN,
    input  logic                  i_TOTAL_VALID,
    output logic [DATA_WIDTH-1:0] o_AVG_DATA,
    output logic                  o_AVG_VALID,
    input  logic                  i_AVG_READY,
    output logic                  o_OVERRUN
);

    typedef enum logic {
        PRIME   = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [LOG2_N:0] C_LAST = {1'b0, {LOG2_N{1'b1}}};

    state_t                r_state;
    logic [LOG2_N:0]       r_count;
    logic [DATA_WIDTH-1:0] r_baseline;
    logic [DATA_WIDTH-1:0] r_avg_data;
    logic                  r_avg_valid;
    logic                  r_overrun;

    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_close;
    logic                  w_slot_free;

    // Modular subtraction absorbs a wrap of the upstream accumulator.
    assign w_diff      = i_TOTAL_IN - r_baseline;
    assign w_result    = w_diff >> LOG2_N;
    assign w_close     = i_TOTAL_VALID && (r_state == COLLECT) && (r_count == C_LAST);
    assign w_slot_free = !r_avg_valid || i_AVG_READY;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state     <= PRIME;
            r_count     <= '0;
            r_baseline  <= '0;
            r_avg_data  <= '0;
            r_avg_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_avg_valid && i_AVG_READY) begin
                r_avg_valid <= 1'b0;
            end
            if (i_TOTAL_VALID) begin
                case (r_state)
                    PRIME: begin
                        r_baseline <= i_TOTAL_IN;
                        r_count    <= '0;
                        r_state    <= COLLECT;
                    end
                    COLLECT: begin
                        if (w_close) begin
                            // Closing total seeds the next window even when the result is dropped.
                            r_baseline <= i_TOTAL_IN;
                            r_count    <= '0;
                            if (w_slot_free) begin
                                r_avg_data  <= w_result;
                                r_avg_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                    default: r_state <= PRIME;
                endcase
            end
        end
    end

    assign o_AVG_DATA  = r_avg_data;
    assign o_AVG_VALID = r_avg_valid;
    assign o_OVERRUN   = r_overrun;

endmodule

// File: doc/accumulator_window_avg.md
Name: accumulator_window_avg

Overview:
- Sits directly downstream of the running-total accumulator.
- Samples the accumulator's 32-bit running total each time it updates.
- Forms the sum over each window of 2^LOG2_N updates as the difference of two totals, then shifts it right to produce the window average.
- Delivers each average on a valid/ready output with a single holding register and a sticky overrun flag.

Parameters:
- DATA_WIDTH, 32, width of the incoming total and of the average output.
- LOG2_N, 3, log2 of the window length. N = 2^LOG2_N updates per window. Legal range 1..8.

Ports:
- i_CLK  input  1  Single clock; all logic is on the rising edge.
- i_RESET  input  1  Synchronous, active-high reset.
- i_TOTAL_IN  input  DATA_WIDTH  Accumulator running total.
- i_TOTAL_VALID  input  1  High for one cycle when i_TOTAL_IN holds a newly updated total.
- o_AVG_DATA  output  DATA_WIDTH  Window average.
- o_AVG_VALID  output  1  o_AVG_DATA is pending.
- i_AVG_READY  input  1  Consumer accepts o_AVG_DATA when this and o_AVG_VALID are both high.
- o_OVERRUN  output  1  Sticky: a window result was dropped.

Behaviour:
- Interface: one clock, i_CLK. Reset is synchronous and active-high on i_RESET.
- Reset values: o_AVG_DATA=0, o_AVG_VALID=0, o_OVERRUN=0, baseline=0, count=0, state=PRIME. Reset has priority over every other input in the same cycle.
- State PRIME: the first i_TOTAL_VALID after reset loads baseline<=i_TOTAL_IN and count<=0, then moves to COLLECT. No output is produced in PRIME.
- State COLLECT: each i_TOTAL_VALID increments count. Count width is LOG2_N+1.
- Window complete: i_TOTAL_VALID arrives while count==N-1 (the Nth update after baseline). On that edge:
  - diff = (i_TOTAL_IN - baseline) mod 2^DATA_WIDTH. Unsigned modular arithmetic, so accumulator wrap is handled.
  - result = diff >> LOG2_N, logical shift, truncating.
  - baseline<=i_TOTAL_IN; count<=0. Windows are back-to-back and the closing total is the next window's baseline.
- Latency: o_AVG_VALID rises on the edge after the cycle holding the closing i_TOTAL_VALID (1 cycle). o_AVG_DATA is registered.
- Handshake:
  - o_AVG_VALID stays high and o_AVG_DATA stays stable until a cycle with i_AVG_READY=1.
  - o_AVG_VALID clears on the edge ending that cycle, unless a new result loads on the same edge.
- Simultaneous accept and new result (valid&&ready in the same cycle as a window completion): the new result loads, o_AVG_VALID stays 1, no overrun.
- Overrun: a window completes while o_AVG_VALID=1 and i_AVG_READY=0.
  - The new result is discarded; the held o_AVG_DATA is unchanged.
  - o_OVERRUN<=1 and stays set until reset.
  - baseline and count still advance, so window alignment is preserved.
- i_TOTAL_VALID low: all window state holds. i_TOTAL_IN is ignored.
- Reset mid-window or with a result pending: the pending result and partial window are discarded and the block returns to PRIME.
- i_AVG_READY while o_AVG_VALID=0: no effect.

Test Plan (LOG2_N=3, N=8):
- Basic window: reset, then i_TOTAL_VALID pulses with totals 100,110,...,180 (9 pulses) -> one cycle after the 180 pulse, o_AVG_VALID=1, o_AVG_DATA=10. i_AVG_READY=1 -> o_AVG_VALID=0 next cycle.
- Wrap-around: baseline 0xFFFFFFF0, seven intermediate totals, closing total 0x00000070 -> diff 0x80, o_AVG_DATA=0x10, o_OVERRUN=0.
- Truncation and back-to-back windows: baseline 0, closing total 15 -> avg 1. Next window closes at 31 (diff 16) -> avg 2.
- Backpressure overrun: hold i_AVG_READY=0 across two window completions (avg 10 then avg 20) -> o_AVG_DATA stays 10 and o_OVERRUN=1. Then assert ready -> o_AVG_VALID=0. The third window computes from the correct baseline.
- Simultaneous accept: i_AVG_READY=1 in the exact cycle a second window closes -> o_AVG_VALID stays 1, o_AVG_DATA updates to the new average, o_OVERRUN=0.
- Reset mid-operation: assert i_RESET after 4 updates of a window and with a result pending -> next cycle all outputs are 0. The next i_TOTAL_VALID is taken as the baseline, and the first result appears only after 8 further updates.
